oric_raster_gen: RTL and testbench

Parametrised raster timing generator for the next-generation Oric video path. It generalises the fixed 12-clock cell, 64-cell line and 312/264-line frame counters into configurable totals, sync windows and active windows. Outputs are registered cell and line strobes, counters, blanking and sync, and a frame counter with a blink bit. Downstream DMA addressing and pixel serialiser blocks consume these outputs.

---
 rtl/oric_raster_gen.sv | 165 ++++++++++++++++
 tb/tb_oric_raster_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oric_raster_gen.sv
// oric_raster_gen: parametrised cell/line/frame raster timing generator for the Oric video path.
// Define RASTER_IRQ_EN to add the raster-line interrupt (IRQ_LINE, IRQ_ACK, IRQ).
module oric_raster_gen #(
  parameter int CELL_CLKS   = 12,
  parameter int H_TOTAL     = 64,
  parameter int H_ACTIVE    = 40,
  parameter int HS_START    = 48,
  parameter int HS_WIDTH    = 4,
  parameter int V_TOTAL_50  = 312,
  parameter int V_TOTAL_60  = 264,
  parameter int V_ACTIVE    = 224,
  parameter int VS_START_50 = 256,
  parameter int VS_START_60 = 236,
  parameter int VS_WIDTH    = 4,
  parameter int FCNT_W      = 5,
  localparam int PW     = (CELL_CLKS > 1) ? $clog2(CELL_CLKS) : 1,
  localparam int HW     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1,
  localparam int V_MAX  = (V_TOTAL_50 > V_TOTAL_60) ? V_TOTAL_50 : V_TOTAL_60,
  localparam int V_MIN  = (V_TOTAL_50 < V_TOTAL_60) ? V_TOTAL_50 : V_TOTAL_60,
  localparam int VW     = (V_MAX > 1) ? $clog2(V_MAX) : 1
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              MODE_60HZ,
  output logic [PW-1:0]     CELL_PHASE,
  output logic              CELL_STB,
  output logic [HW-1:0]     HCNT,
  output logic [VW-1:0]     VCNT,
  output logic              LINE_START,
  output logic              FRAME_START,
  output logic              HACTIVE,
  output logic              VACTIVE,
  output logic              ACTIVE,
  output logic              nHSYNC,
  output logic              nVSYNC,
  output logic              nCSYNC,
  output logic              MODE_60HZ_Q,
  output logic [FCNT_W-1:0] FCNT,
`ifdef RASTER_IRQ_EN
  input  logic [VW-1:0]     IRQ_LINE,
  input  logic              IRQ_ACK,
  output logic              IRQ,
`endif
  output logic              BLINK
);

  if (CELL_CLKS < 2) begin : g_chk_cell
    $error("CELL_CLKS must be at least 2");
  end
  if (HS_START + HS_WIDTH > H_TOTAL) begin : g_chk_hs
    $error("hsync window exceeds H_TOTAL");
  end
  if (VS_START_50 + VS_WIDTH > V_TOTAL_50) begin : g_chk_vs50
    $error("50 Hz vsync window exceeds V_TOTAL_50");
  end
  if (VS_START_60 + VS_WIDTH > V_TOTAL_60) begin : g_chk_vs60
    $error("60 Hz vsync window exceeds V_TOTAL_60");
  end
  if (H_ACTIVE > H_TOTAL) begin : g_chk_hact
    $error("H_ACTIVE exceeds H_TOTAL");
  end
  if (V_ACTIVE > V_MIN) begin : g_chk_vact
    $error("V_ACTIVE exceeds the shorter frame total");
  end

  // Window bounds are one bit wider than the counters so an end equal to the total still fits.
  localparam logic [PW-1:0] PH_LAST   = PW'(CELL_CLKS - 1);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST_50 = VW'(V_TOTAL_50 - 1);
  localparam logic [VW-1:0] V_LAST_60 = VW'(V_TOTAL_60 - 1);
  localparam logic [HW:0]   H_ACT_END = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0]   HS_LO     = (HW+1)'(HS_START);
  localparam logic [HW:0]   HS_HI     = (HW+1)'(HS_START + HS_WIDTH);
  localparam logic [VW:0]   V_ACT_END = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0]   VS_LO_50  = (VW+1)'(VS_START_50);
  localparam logic [VW:0]   VS_HI_50  = (VW+1)'(VS_START_50 + VS_WIDTH);
  localparam logic [VW:0]   VS_LO_60  = (VW+1)'(VS_START_60);
  localparam logic [VW:0]   VS_HI_60  = (VW+1)'(VS_START_60 + VS_WIDTH);

  logic              phase_wrap_p0, h_wrap_p0, v_wrap_p0;
  logic [PW-1:0]     phase_p0;
  logic [HW-1:0]     hcnt_p0;
  logic [VW-1:0]     vcnt_p0;
  logic [FCNT_W-1:0] fcnt_p0;
  logic              mode_p0;
  logic              line_start_p0, frame_start_p0;
  logic              hact_p0, vact_p0, hs_on_p0, vs_on_p0;
  logic [VW:0]       vs_lo_p0, vs_hi_p0;

  // Stage 0: next-state counters and the flags that describe them.
  always_comb begin
    phase_wrap_p0 = (CELL_PHASE == PH_LAST);
    h_wrap_p0     = phase_wrap_p0 && (HCNT == H_LAST);
    v_wrap_p0     = h_wrap_p0 && (VCNT == (MODE_60HZ_Q ? V_LAST_60 : V_LAST_50));

    phase_p0 = phase_wrap_p0 ? '0 : CELL_PHASE + 1'b1;
    hcnt_p0  = HCNT;
    if (phase_wrap_p0) hcnt_p0 = (HCNT == H_LAST) ? '0 : HCNT + 1'b1;
    vcnt_p0  = VCNT;
    if (h_wrap_p0) vcnt_p0 = v_wrap_p0 ? '0 : VCNT + 1'b1;

    // The requested mode is only taken at a frame wrap so frames are never cut short.
    mode_p0 = v_wrap_p0 ? MODE_60HZ : MODE_60HZ_Q;
    fcnt_p0 = v_wrap_p0 ? FCNT + 1'b1 : FCNT;

    vs_lo_p0 = mode_p0 ? VS_LO_60 : VS_LO_50;
    vs_hi_p0 = mode_p0 ? VS_HI_60 : VS_HI_50;

    line_start_p0  = (phase_p0 == '0) && (hcnt_p0 == '0);
    frame_start_p0 = line_start_p0 && (vcnt_p0 == '0);
    hact_p0  = ({1'b0, hcnt_p0} < H_ACT_END);
    vact_p0  = ({1'b0, vcnt_p0} < V_ACT_END);
    hs_on_p0 = ({1'b0, hcnt_p0} >= HS_LO) && ({1'b0, hcnt_p0} < HS_HI);
    vs_on_p0 = ({1'b0, vcnt_p0} >= vs_lo_p0) && ({1'b0, vcnt_p0} < vs_hi_p0);
  end

  // Stage 1: registered counters and flags, aligned with each other.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      CELL_PHASE  <= '0;
      CELL_STB    <= 1'b0;
      HCNT        <= '0;
      VCNT        <= '0;
      FCNT        <= '0;
      MODE_60HZ_Q <= 1'b0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
      HACTIVE     <= 1'b1;
      VACTIVE     <= 1'b1;
      ACTIVE      <= 1'b1;
      nHSYNC      <= 1'b1;
      nVSYNC      <= 1'b1;
      nCSYNC      <= 1'b1;
    end else begin
      CELL_PHASE  <= phase_p0;
      CELL_STB    <= (phase_p0 == PH_LAST);
      HCNT        <= hcnt_p0;
      VCNT        <= vcnt_p0;
      FCNT        <= fcnt_p0;
      MODE_60HZ_Q <= mode_p0;
      LINE_START  <= line_start_p0;
      FRAME_START <= frame_start_p0;
      HACTIVE     <= hact_p0;
      VACTIVE     <= vact_p0;
      ACTIVE      <= hact_p0 && vact_p0;
      nHSYNC      <= !hs_on_p0;
      nVSYNC      <= !vs_on_p0;
      nCSYNC      <= !hs_on_p0 && !vs_on_p0;
    end
  end

  assign BLINK = FCNT[FCNT_W-1];

`ifdef RASTER_IRQ_EN
  // A new set outranks an acknowledge arriving in the same cycle.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      IRQ <= 1'b0;
    end else begin
      IRQ <= (line_start_p0 && (vcnt_p0 == IRQ_LINE)) || (IRQ && !IRQ_ACK);
    end
  end
`endif

endmodule

// File: tb/tb_oric_raster_gen.sv
// Self-checking bench for oric_raster_gen on a scaled-down raster, against a frame-position model.
// Covers the RASTER_IRQ_EN build when that macro is defined.
module tb_oric_raster_gen;
  localparam int C = 3, H = 16, HA = 10, HSS = 12, HSW = 2;
  localparam int V50 = 20, V60 = 16, VA = 12, VS50 = 15, VS60 = 13, VSW = 2, FW = 3;
  localparam int PW = $clog2(C), HW = $clog2(H), VW = $clog2(V50);
  localparam int LINE = C * H;

  logic          CLK = 1'b0;
  logic          nRESET = 1'b0;
  logic          MODE_60HZ = 1'b0;
  logic [PW-1:0] CELL_PHASE;
  logic          CELL_STB;
  logic [HW-1:0] HCNT;
  logic [VW-1:0] VCNT;
  logic          LINE_START, FRAME_START, HACTIVE, VACTIVE, ACTIVE;
  logic          nHSYNC, nVSYNC, nCSYNC, MODE_60HZ_Q, BLINK;
  logic [FW-1:0] FCNT;
`ifdef RASTER_IRQ_EN
  logic [VW-1:0] IRQ_LINE = VW'(7);
  logic          IRQ_ACK = 1'b0;
  logic          IRQ;
`endif

  oric_raster_gen #(
    .CELL_CLKS(C), .H_TOTAL(H), .H_ACTIVE(HA), .HS_START(HSS), .HS_WIDTH(HSW),
    .V_TOTAL_50(V50), .V_TOTAL_60(V60), .V_ACTIVE(VA), .VS_START_50(VS50),
    .VS_START_60(VS60), .VS_WIDTH(VSW), .FCNT_W(FW)
  ) dut (
    .CLK(CLK), .nRESET(nRESET), .MODE_60HZ(MODE_60HZ),
    .CELL_PHASE(CELL_PHASE), .CELL_STB(CELL_STB), .HCNT(HCNT), .VCNT(VCNT),
    .LINE_START(LINE_START), .FRAME_START(FRAME_START),
    .HACTIVE(HACTIVE), .VACTIVE(VACTIVE), .ACTIVE(ACTIVE),
    .nHSYNC(nHSYNC), .nVSYNC(nVSYNC), .nCSYNC(nCSYNC),
    .MODE_60HZ_Q(MODE_60HZ_Q), .FCNT(FCNT),
`ifdef RASTER_IRQ_EN
    .IRQ_LINE(IRQ_LINE), .IRQ_ACK(IRQ_ACK), .IRQ(IRQ),
`endif
    .BLINK(BLINK)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  // Reference state: clocks elapsed since the current frame began, mode in force, frame count.
  int t = 0;
  bit m_mode = 1'b0;
  int m_fcnt = 0;
  bit m_irq = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int frame_len(input bit m);
    return LINE * (m ? V60 : V50);
  endfunction

  task automatic model_edge(input bit mode_in, input int irq_line, input bit irq_ack);
    bit set;
    t++;
    if (t == frame_len(m_mode)) begin
      t = 0;
      m_mode = mode_in;
      m_fcnt = (m_fcnt + 1) % (1 << FW);
    end
    set = ((t % LINE) == 0) && ((t / LINE) == irq_line);
    m_irq = set || (m_irq && !irq_ack);
  endtask

  task automatic check_all();
    int ph, hc, vc, vss;
    bit hs, vs;
    ph  = t % C;
    hc  = (t / C) % H;
    vc  = t / LINE;
    vss = m_mode ? VS60 : VS50;
    hs  = (hc >= HSS) && (hc < HSS + HSW);
    vs  = (vc >= vss) && (vc < vss + VSW);
    check("phase", 32'(CELL_PHASE), ph);
    check("cell_stb", 32'(CELL_STB), 32'(ph == C - 1));
    check("hcnt", 32'(HCNT), hc);
    check("vcnt", 32'(VCNT), vc);
    check("line_start", 32'(LINE_START), 32'((t % LINE) == 0));
    check("frame_start", 32'(FRAME_START), 32'(t == 0));
    check("hactive", 32'(HACTIVE), 32'(hc < HA));
    check("vactive", 32'(VACTIVE), 32'(vc < VA));
    check("active", 32'(ACTIVE), 32'((hc < HA) && (vc < VA)));
    check("nhsync", 32'(nHSYNC), 32'(!hs));
    check("nvsync", 32'(nVSYNC), 32'(!vs));
    check("ncsync", 32'(nCSYNC), 32'(!hs && !vs));
    check("mode_q", 32'(MODE_60HZ_Q), 32'(m_mode));
    check("fcnt", 32'(FCNT), m_fcnt);
    check("blink", 32'(BLINK), 32'(m_fcnt >= (1 << (FW - 1))));
`ifdef RASTER_IRQ_EN
    check("irq", 32'(IRQ), 32'(m_irq));
`endif
  endtask

  task automatic check_reset();
    check("rst_phase", 32'(CELL_PHASE), 0);
    check("rst_stb", 32'(CELL_STB), 0);
    check("rst_hcnt", 32'(HCNT), 0);
    check("rst_vcnt", 32'(VCNT), 0);
    check("rst_fcnt", 32'(FCNT), 0);
    check("rst_mode_q", 32'(MODE_60HZ_Q), 0);
    check("rst_line_start", 32'(LINE_START), 0);
    check("rst_frame_start", 32'(FRAME_START), 0);
    check("rst_active", 32'({HACTIVE, VACTIVE, ACTIVE}), 7);
    check("rst_sync", 32'({nHSYNC, nVSYNC, nCSYNC}), 7);
    check("rst_blink", 32'(BLINK), 0);
`ifdef RASTER_IRQ_EN
    check("rst_irq", 32'(IRQ), 0);
`endif
  endtask

  task automatic step();
    bit mi, ack;
    int il;
    mi = MODE_60HZ;
    il = 1 << 20;
    ack = 1'b0;
`ifdef RASTER_IRQ_EN
    il = int'(IRQ_LINE);
    ack = IRQ_ACK;
`endif
    @(posedge CLK);
    model_edge(mi, il, ack);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #($urandom_range(1, 8));
    nRESET = 1'b0;
    #1;
    check_reset();
    @(posedge CLK);
    #1;
    check_reset();
    @(negedge CLK);
    nRESET = 1'b1;
    t = 0;
    m_mode = 1'b0;
    m_fcnt = 0;
    m_irq = 1'b0;
    #1;
    check_reset();
  endtask

  // Runs to the next FRAME_START; reports clocks taken and the largest VCNT seen on the way.
  task automatic run_to_frame(output int n, output int vmax);
    n = 0;
    vmax = 0;
    do begin
      step();
      n++;
      if (int'(VCNT) > vmax) vmax = int'(VCNT);
    end while (!FRAME_START && n < 3 * frame_len(1'b0));
    check("frame_seen", 32'(FRAME_START), 1);
  endtask

  task automatic run_to_line(input int vline);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(int'(VCNT) == vline && LINE_START) && n < 3 * frame_len(1'b0));
    check("line_seen", 32'(VCNT), vline);
  endtask

  initial begin
    int n, vmax, lo_h, lo_ha, f0;
    do_reset();

    run_to_frame(n, vmax);
    check("first_frame_50", n, frame_len(1'b0));
    run_to_frame(n, vmax);
    check("period_50", n, frame_len(1'b0));
    check("vmax_50", vmax, V50 - 1);

    lo_h = 0;
    lo_ha = 0;
    for (int i = 0; i < LINE; i++) begin
      step();
      if (!nHSYNC) lo_h++;
      if (!HACTIVE) lo_ha++;
    end
    check("hsync_low_clks", lo_h, HSW * C);
    check("hactive_low_clks", lo_ha, (H - HA) * C);

    MODE_60HZ = 1'b1;
    run_to_frame(n, vmax);
    check("mode_q_after_wrap", 32'(MODE_60HZ_Q), 1);
    run_to_frame(n, vmax);
    check("period_60", n, frame_len(1'b1));
    check("vmax_60", vmax, V60 - 1);

    MODE_60HZ = 1'b0;
    run_to_frame(n, vmax);
    run_to_line(8);
    MODE_60HZ = 1'b1;
    run_to_frame(n, vmax);
    check("toggled_frame_vmax", vmax, V50 - 1);
    run_to_frame(n, vmax);
    check("next_frame_len", n, frame_len(1'b1));
    check("next_frame_vmax", vmax, V60 - 1);

    f0 = int'(FCNT);
    for (int i = 0; i < (1 << FW); i++) run_to_frame(n, vmax);
    check("fcnt_full_wrap", 32'(FCNT), f0);

`ifdef RASTER_IRQ_EN
    IRQ_LINE = VW'(7);
    run_to_line(7);
    check("irq_rise", 32'({IRQ, HCNT, CELL_PHASE}), 32'({1'b1, HW'(0), PW'(0)}));
    for (int i = 0; i < 40; i++) step();
    check("irq_hold", 32'(IRQ), 1);
    IRQ_ACK = 1'b1;
    step();
    IRQ_ACK = 1'b0;
    check("irq_acked", 32'(IRQ), 0);
    IRQ_LINE = VW'(V50 + 3);
    for (int i = 0; i < frame_len(1'b1) + 8; i++) step();
    IRQ_LINE = VW'(7);
    run_to_line(7);
    for (int i = 0; i < 4 * C + 1; i++) step();
    check("irq_before_reset", 32'(IRQ), 1);
`endif
    do_reset();

    for (int i = 0; i < 16000; i++) begin
      step();
      if ($urandom_range(0, 399) == 0) MODE_60HZ = ~MODE_60HZ;
`ifdef RASTER_IRQ_EN
      IRQ_ACK = ($urandom_range(0, 99) == 0);
      if (FRAME_START) IRQ_LINE = VW'($urandom_range(0, V50 + 3));
`endif
      if ($urandom_range(0, 5999) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
